// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store memory stage: op-bus field ranges, opcodes,
// funct3 access sizes, FSM states and the op legality check.
package lsu_mem_stage_pkg;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeMsb = 6;
  localparam int unsigned Funct3Lsb = 7;
  localparam int unsigned Funct3Msb = 9;
  localparam int unsigned Funct7Lsb = 10;
  localparam int unsigned Funct7Msb = 16;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StDone} lsu_state_e;

  // Opcode/funct3 legality only; alignment is checked separately by lsu_align.
  function automatic logic op_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    if (opcode == OpcLoad) begin
      return funct3 inside {F3B, F3H, F3W, F3Bu, F3Hu};
    end
    if (opcode == OpcStore) begin
      return funct3 inside {F3B, F3H, F3W};
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte strobes and replication, load byte/half
// extraction with sign or zero extension, and the misalignment flag.
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  assign shifted  = mem_rdata >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // funct3[2] set marks the unsigned load variants.
  assign sign_ext = ~funct3[2];

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = 32'h0;
    load_val  = 32'h0;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_val  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_val  = {{16{sign_ext & half_sel[15]}}, half_sel};
        misalign  = addr_lo[0];
      end
      2'b10: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        load_val  = mem_rdata;
        misalign  = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: latches an ALU-computed address, runs one req/ready handshake
// to data memory and returns an extended load value or a store completion.
module lsu_mem_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [16:0]     op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  import lsu_mem_stage_pkg::*;

  lsu_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            is_store_q, is_store_d;
  logic [31:0]     wait_cnt_q, wait_cnt_d;
  logic            busy_d, done_d, err_d, mem_req_d, mem_we_d;
  logic [XLEN-1:0] rdata_d, mem_addr_d, mem_wdata_d;
  logic [3:0]      mem_wstrb_d;

  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_legal;
  logic [2:0]  align_funct3;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        align_misalign;
  logic        unused_funct7;

  assign in_opcode     = op[OpcodeMsb:OpcodeLsb];
  assign in_funct3     = op[Funct3Msb:Funct3Lsb];
  assign unused_funct7 = ^op[Funct7Msb:Funct7Lsb];

  // The aligner sees the incoming op while idle and the latched op afterwards.
  assign align_funct3  = (state_q == StIdle) ? in_funct3 : funct3_q;
  assign align_addr_lo = (state_q == StIdle) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3    (align_funct3),
    .addr_lo   (align_addr_lo),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .wstrb     (align_wstrb),
    .wdata_rep (align_wdata),
    .load_val  (align_load),
    .misalign  (align_misalign)
  );

  assign in_legal = op_legal(in_opcode, in_funct3) & ~align_misalign;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    is_store_d  = is_store_q;
    wait_cnt_d  = wait_cnt_q;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    rdata_d     = rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wstrb_d = mem_wstrb;
    mem_wdata_d = mem_wdata;

    unique case (state_q)
      StIdle: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        if (start) begin
          funct3_d   = in_funct3;
          addr_lo_d  = addr[1:0];
          is_store_d = (in_opcode == OpcStore);
          busy_d     = 1'b1;
          if (in_legal) begin
            state_d     = StReq;
            err_d       = 1'b0;
            wait_cnt_d  = 32'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = (in_opcode == OpcStore);
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = (in_opcode == OpcStore) ? align_wstrb : 4'b0000;
            mem_wdata_d = (in_opcode == OpcStore) ? align_wdata : '0;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d   = StDone;
          done_d    = 1'b1;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          if (!is_store_q) begin
            rdata_d = align_load;
          end
        end else if ((TIMEOUT != 0) && ((wait_cnt_q + 32'd1) == TIMEOUT)) begin
          state_d   = StDone;
          done_d    = 1'b1;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      is_store_q <= 1'b0;
      wait_cnt_q <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      is_store_q <= is_store_d;
      wait_cnt_q <= wait_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      rdata      <= rdata_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wstrb  <= mem_wstrb_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule
